instruction_dispatcher: RTL and testbench

INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

---
 rtl/instruction_dispatcher.sv | 151 +++++++++++++++
 tb/tb_instruction_dispatcher.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_dispatcher.sv
// instruction_dispatcher
//   Buffers {dataA,dataB} instruction pairs from the processor in a FIFO and
//   hands them to the decoder one at a time. Entries whose opcode
//   (dataA[3:0]) is not 0..3 are discarded. Each valid instruction is
//   presented with a one-cycle clk_en pulse. The block then waits for the
//   control unit's done pulse, or gives up after TIMEOUT cycles.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-low reset
//   wrreg, dataA, dataB      processor write strobe + instruction words
//   done                     control unit finished the current instruction
//   out_dataA, out_dataB     instruction held for the decoder
//   clk_en, new_instruction  issue pulse (high) / its complement
//   full, empty, busy        FIFO status, FSM not idle
//   overflow, timeout_err    sticky error flags
//   drop_count               invalid-opcode drops, saturating at 255
module instruction_dispatcher #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wrreg,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        done,
  output logic [31:0] out_dataA,
  output logic [31:0] out_dataB,
  output logic        clk_en,
  output logic        new_instruction,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        overflow,
  output logic        timeout_err,
  output logic [7:0]  drop_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  entry_t         r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_wait_cnt;
  logic [31:0]    r_out_a, r_out_b;
  logic           r_overflow, r_timeout_err;
  logic [7:0]     r_drop_count;

  entry_t         w_head;
  logic           w_full, w_empty, w_wr, w_pop, w_head_valid, w_timeout;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  // Acceptance uses the pre-pop count, so a full FIFO rejects a write even
  // when a pop frees a slot in the same cycle.
  assign w_wr         = wrreg && !w_full;
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_valid = (w_head.a[3:2] == 2'b00);

  // Storage carries no reset; a flush is just a pointer/count clear.
  always_ff @(posedge clk) begin
    if (reset && w_wr) r_mem[r_wr_ptr] <= '{a: dataA, b: dataB};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_pop && w_head_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // done wins over a coinciding timeout
        if (done) w_state_nxt = S_IDLE;
        else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clk_en          = 1'b0;
    new_instruction = 1'b1;
    busy            = 1'b0;
    if (r_state == S_ISSUE) begin
      clk_en          = 1'b1;
      new_instruction = 1'b0;
    end
    if (r_state != S_IDLE) busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_wait_cnt    <= '0;
      r_out_a       <= '0;
      r_out_b       <= '0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (wrreg && w_full) r_overflow <= 1'b1;
      if (w_timeout)       r_timeout_err <= 1'b1;

      if (w_pop) begin
        if (w_head_valid) begin
          r_out_a <= w_head.a;
          r_out_b <= w_head.b;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end

      // Counter is held at zero outside WAIT, so it starts from 0 on entry.
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                   r_wait_cnt <= '0;
    end
  end

  assign out_dataA   = r_out_a;
  assign out_dataB   = r_out_b;
  assign full        = w_full;
  assign empty       = w_empty;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;
  assign drop_count  = r_drop_count;
endmodule

// File: tb/tb_instruction_dispatcher.sv
module tb_instruction_dispatcher;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, wrreg, done;
  logic [31:0] dataA, dataB;
  logic [31:0] out_dataA, out_dataB;
  logic        clk_en, new_instruction, full, empty, busy, overflow, timeout_err;
  logic [7:0]  drop_count;

  instruction_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wrreg(wrreg), .dataA(dataA), .dataB(dataB),
    .done(done), .out_dataA(out_dataA), .out_dataB(out_dataB),
    .clk_en(clk_en), .new_instruction(new_instruction), .full(full),
    .empty(empty), .busy(busy), .overflow(overflow),
    .timeout_err(timeout_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;
  bit chk_on   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending instructions plus two flags saying
  // whether an instruction is being presented or awaiting completion.
  logic [63:0] mq[$];
  bit          m_issue, m_inflight, m_ovf, m_terr;
  int          m_wcnt, m_drop;
  logic [31:0] m_oa, m_ob;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_issue = 0; m_inflight = 0; m_ovf = 0; m_terr = 0;
      m_wcnt = 0; m_drop = 0; m_oa = 0; m_ob = 0;
    end else begin
      bit idle, wr_ok, nxt_issue;
      logic [63:0] e;
      idle      = !m_issue && !m_inflight;
      wr_ok     = wrreg && (mq.size() < DEPTH);
      nxt_issue = 0;
      if (wrreg && !wr_ok) m_ovf = 1;
      if (idle && mq.size() > 0) begin
        e = mq.pop_front();
        if (e[35:32] < 4) begin
          m_oa = e[63:32]; m_ob = e[31:0]; nxt_issue = 1;
        end else if (m_drop < 255) m_drop++;
      end
      if (m_issue) begin
        m_inflight = 1; m_wcnt = 0;
      end else if (m_inflight) begin
        if (done) m_inflight = 0;
        else if (m_wcnt == TIMEOUT - 1) begin m_inflight = 0; m_terr = 1; end
        else m_wcnt++;
      end
      if (wr_ok) mq.push_back({dataA, dataB});
      m_issue = nxt_issue;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("clk_en", clk_en, m_issue);
      chk("new_instruction", new_instruction, !m_issue);
      chk("busy", busy, m_issue || m_inflight);
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("out_dataA", out_dataA, m_oa);
      chk("out_dataB", out_dataB, m_ob);
      chk("overflow", overflow, m_ovf);
      chk("timeout_err", timeout_err, m_terr);
      chk("drop_count", drop_count, m_drop);
      pulses += clk_en;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int p0;
    reset = 0; wrreg = 0; done = 0; dataA = 0; dataB = 0;
    tick(2);
    reset = 1;
    chk_on = 1;
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_newinstr", new_instruction, 1);
    chk("rst_outA", out_dataA, 0);
    chk("rst_drop", drop_count, 0);

    // single issue, two-cycle latency
    wrreg = 1; dataA = 32'h10; dataB = 32'h00640032;
    tick(); wrreg = 0;
    chk("si_idle_before_pop", clk_en, 0);
    tick();
    chk("si_clk_en", clk_en, 1);
    chk("si_outA", out_dataA, 32'h10);
    chk("si_outB", out_dataB, 32'h00640032);
    chk("si_newinstr", new_instruction, 0);
    tick(); done = 1;
    chk("si_wait_busy", busy, 1);
    tick(); done = 0;
    chk("si_done_busy", busy, 0);

    // invalid opcodes are dropped
    p0 = pulses;
    wrreg = 1; dataA = 32'h5; tick();
    dataA = 32'hF; tick();
    dataA = 32'hA1; tick();
    wrreg = 0; tick();
    chk("drop_clk_en", clk_en, 1);
    chk("drop_outA", out_dataA, 32'hA1);
    chk("drop_count2", drop_count, 2);
    chk("model_drop2", m_drop, 2);
    tick(); done = 1; tick(); done = 0; tick();
    chk("drop_one_pulse", pulses - p0, 1);

    // fill: first entry issues, eight more fill the FIFO, tenth overflows
    for (int k = 1; k <= 10; k++) begin
      wrreg = 1; dataA = 32'h100 * k + (k % 4); dataB = k;
      tick();
      if (k == 9) begin
        chk("fill_full", full, 1);
        chk("fill_no_ovf", overflow, 0);
        chk("model_size8", mq.size(), 8);
      end
    end
    wrreg = 0;
    chk("fill_ovf", overflow, 1);
    chk("fill_still_full", full, 1);

    // timeout, then the next queued entry issues
    for (int i = 0; i < 40 && !timeout_err; i++) tick();
    chk("to_seen", timeout_err, 1);
    chk("to_idle", busy, 0);
    tick();
    chk("to_next_issue", clk_en, 1);
    chk("to_next_outA", out_dataA, 32'h202);

    // reset mid-WAIT flushes everything; write during reset ignored
    tick();
    chk("rw_wait", busy, 1);
    chk("rw_queued", mq.size() >= 3, 1);
    reset = 0; wrreg = 1; dataA = 32'h1;
    tick();
    reset = 1; wrreg = 0;
    chk("rw_empty", empty, 1);
    chk("rw_busy", busy, 0);
    chk("rw_newinstr", new_instruction, 1);
    chk("rw_terr_clr", timeout_err, 0);
    p0 = pulses;
    tick(5);
    chk("rw_no_pulse", pulses - p0, 0);

    // randomized traffic, including rare resets
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] r;
      r = $urandom;
      wrreg = ($urandom_range(99) < 45);
      dataA = {r[31:4], ($urandom_range(99) < 80) ? 4'($urandom_range(3)) : 4'($urandom_range(15))};
      dataB = $urandom;
      done  = ($urandom_range(99) < 25);
      reset = ($urandom_range(399) != 0);
      tick();
    end
    reset = 1; wrreg = 0; done = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
